// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Instruction memory front-end for a five-stage CPU. Receives a
//             program image from the host over a valid/ready stream, writes it
//             into on-chip word RAM, holds the CPU in reset while loading,
//             releases it after RST_CYC cycles, then serves 0-cycle fetches.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1     clock
//    reset        in   1     asynchronous active-low reset
//    load_start   in   1     begin a load; load_len sampled with it
//    load_len     in   AW+1  words to load, legal 1..2**AW
//    load_valid   in   1     host word valid
//    load_data    in   32    host word
//    load_cksum   in   32    expected XOR of the image (LOAD_CKSUM_EN only)
//    cksum_err    out  1     checksum mismatch flag    (LOAD_CKSUM_EN only)
//    load_ready   out  1     a word is accepted this cycle when valid
//    pc           in   32    CPU program counter
//    inst         out  32    instruction at pc (combinational)
//    cpu_reset    out  1     active-high CPU reset, registered
//    running      out  1     CPU running
//    pc_oob       out  1     sticky invalid-fetch flag
//    words_loaded out  AW+1  words written by the current/last load
//  Configuration macro
//    LOAD_CKSUM_EN : adds XOR checksum verification of the loaded image.
// ============================================================================
module imem_loader #(
    parameter int          AW       = 7,
    parameter int          RST_CYC  = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic [AW:0]   load_len,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
`ifdef LOAD_CKSUM_EN
    input  logic [31:0]   load_cksum,
    output logic          cksum_err,
`endif
    output logic          load_ready,
    input  logic [31:0]   pc,
    output logic [31:0]   inst,
    output logic          cpu_reset,
    output logic          running,
    output logic          pc_oob,
    output logic [AW:0]   words_loaded
);

    localparam int          c_NMEM    = 2 ** AW;
    localparam logic [AW:0] c_NMEM_W  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] c_ONE_W   = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [AW:0]   r_len;
    logic [AW:0]   r_words;
    logic [3:0]    r_rst_cnt;
    logic          r_load_ready;
    logic          r_cpu_reset;
    logic          r_running;
    logic          r_pc_oob;
    logic [31:0]   r_mem [c_NMEM];

    logic          w_len_ok;
    logic          w_start_acc;
    logic          w_xfer;
    logic          w_last_xfer;
    logic          w_cksum_ok;
    logic [AW-1:0] w_fetch_idx;
    logic          w_addr_ok;
    logic          w_fetch_ok;
    logic          w_fetch_bad;

    // A start is only honoured when the block is not in the middle of a load
    // or a reset release.
    assign w_len_ok    = (load_len != '0) && (load_len <= c_NMEM_W);
    assign w_start_acc = load_start && w_len_ok &&
                         ((r_state == S_IDLE) || (r_state == S_RUN));

    // load_ready is only ever high in LOAD, so it doubles as the state qualifier.
    assign w_xfer      = load_valid && r_load_ready;
    assign w_last_xfer = w_xfer && (r_words == (r_len - c_ONE_W));

`ifdef LOAD_CKSUM_EN
    logic [31:0] r_xor;
    logic [31:0] r_cksum;
    logic        r_cksum_err;

    // The last word is still on load_data when the comparison is made, so it
    // is folded in here rather than waiting for r_xor to update.
    assign w_cksum_ok = ((r_xor ^ load_data) == r_cksum);
    assign cksum_err  = r_cksum_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_xor       <= '0;
            r_cksum     <= '0;
            r_cksum_err <= 1'b0;
        end else if (w_start_acc) begin
            r_xor       <= '0;
            r_cksum     <= load_cksum;
            r_cksum_err <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_xor <= r_xor ^ load_data;
            end
            if (w_last_xfer && !w_cksum_ok) begin
                r_cksum_err <= 1'b1;
            end
        end
    end
`else
    assign w_cksum_ok = 1'b1;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                if (w_last_xfer) w_next_state = w_cksum_ok ? S_RELEASE : S_IDLE;
            end
            S_RELEASE: begin
                if (r_rst_cnt == 4'd0) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (w_start_acc) w_next_state = S_LOAD;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Fetch decode: word aligned, inside the RAM, and below the loaded length.
    assign w_fetch_idx = pc[AW+1:2];
    assign w_addr_ok   = (pc[31:AW+2] == '0) && (pc[1:0] == 2'b00) &&
                         ({1'b0, w_fetch_idx} < r_words);
    assign w_fetch_ok  = (r_state == S_RUN) && w_addr_ok;
    assign w_fetch_bad = (r_state == S_RUN) && !w_addr_ok;

    assign inst = w_fetch_ok ? r_mem[w_fetch_idx] : NOP_WORD;

    // Outputs are registered from the next state so they line up with the
    // state they describe (e.g. cpu_reset rises the cycle LOAD is entered).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_words      <= '0;
            r_rst_cnt    <= 4'd0;
            r_load_ready <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_running    <= 1'b0;
            r_pc_oob     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_load_ready <= (w_next_state == S_LOAD);
            r_cpu_reset  <= (w_next_state != S_RUN);
            r_running    <= (w_next_state == S_RUN);

            if (w_start_acc) begin
                r_len    <= load_len;
                r_words  <= '0;
                r_pc_oob <= 1'b0;
            end else begin
                if (w_xfer) begin
                    r_words <= r_words + c_ONE_W;
                end
                if (w_fetch_bad) begin
                    r_pc_oob <= 1'b1;
                end
            end

            // RELEASE lasts RST_CYC cycles: load RST_CYC-1, leave at zero.
            if ((r_state == S_LOAD) && (w_next_state == S_RELEASE)) begin
                r_rst_cnt <= 4'(RST_CYC - 1);
            end else if ((r_state == S_RELEASE) && (r_rst_cnt != 4'd0)) begin
                r_rst_cnt <= r_rst_cnt - 4'd1;
            end
        end
    end

    // RAM contents survive reset; only the write port is clocked.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem[r_words[AW-1:0]] <= load_data;
        end
    end

    assign load_ready   = r_load_ready;
    assign cpu_reset    = r_cpu_reset;
    assign running      = r_running;
    assign pc_oob       = r_pc_oob;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader: directed handshake and
//             fetch sequences, a fetch vector table, and randomized loads and
//             fetches compared against an array-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int AW      = 7;
    localparam int NMEM    = 2 ** AW;
    localparam int RST_CYC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          load_valid;
    logic [31:0]   load_data;
    logic          load_ready;
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic          cpu_reset;
    logic          running;
    logic          pc_oob;
    logic [AW:0]   words_loaded;
`ifdef LOAD_CKSUM_EN
    logic [31:0]   load_cksum;
    logic          cksum_err;
`endif

    imem_loader #(.AW(AW), .RST_CYC(RST_CYC), .NOP_WORD(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_len     (load_len),
        .load_valid   (load_valid),
        .load_data    (load_data),
`ifdef LOAD_CKSUM_EN
        .load_cksum   (load_cksum),
        .cksum_err    (cksum_err),
`endif
        .load_ready   (load_ready),
        .pc           (pc),
        .inst         (inst),
        .cpu_reset    (cpu_reset),
        .running      (running),
        .pc_oob       (pc_oob),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: what the host has written and how many words are live.
    logic [31:0] tb_words [NMEM];
    logic [31:0] exp_mem  [NMEM];
    int          exp_len  = 0;
    logic        exp_oob  = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        oob;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit ref_ok(input logic [31:0] p);
        return ((p >> (AW + 2)) == 32'd0) && (p[1:0] == 2'b00) &&
               (int'(p >> 2) < exp_len);
    endfunction

    function automatic logic [31:0] ref_inst(input logic [31:0] p);
        logic [AW-1:0] ix;
        ix = p[AW+1:2];
        return ref_ok(p) ? exp_mem[ix] : 32'h0;
    endfunction

    // mode 0: valid held high, 1: fixed 1,0,0,1,0,1 pattern, 2: random gaps
    task automatic send_load(input int len, input int mode, input bit bad_ck);
        int   idx;
        int   n;
        int   rdy_cyc;
        logic v;
        logic r;
        logic [31:0] x;
        int   pat [6];
        pat = '{1, 0, 0, 1, 0, 1};
        x = 32'h0;
        for (int i = 0; i < len; i++) x = x ^ tb_words[i];
`ifdef LOAD_CKSUM_EN
        load_cksum = bad_ck ? 32'h0 : x;
`else
        if (bad_ck) x = 32'h0;
`endif
        load_start = 1'b1;
        load_len   = (AW+1)'(len);
        cyc();
        load_start = 1'b0;
        exp_oob    = 1'b0;
        check("start cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("start running", {31'b0, running}, 32'd0);
        check("start pc_oob", {31'b0, pc_oob}, 32'd0);
        check("start words_loaded", 32'(words_loaded), 32'd0);
`ifdef LOAD_CKSUM_EN
        check("start cksum_err", {31'b0, cksum_err}, 32'd0);
`endif
        idx = 0; n = 0; rdy_cyc = 0;
        while (idx < len && n < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = pat[n % 6] != 0;
                default: v = $urandom_range(0, 2) != 0;
            endcase
            load_valid = v;
            load_data  = v ? tb_words[idx] : $urandom;
            #1;
            r = load_ready;
            if (r) rdy_cyc++;
            @(posedge clk);
            if (v && r) idx++;
            @(negedge clk);
            n++;
        end
        load_valid = 1'b0;
        check("words accepted", 32'(idx), 32'(len));
        check("ready held through load", 32'(rdy_cyc), 32'(n));
        if (mode == 0) check("ready cycles", 32'(rdy_cyc), 32'(len));
        check("ready low after load", {31'b0, load_ready}, 32'd0);
        check("words_loaded", 32'(words_loaded), 32'(len));
        for (int i = 0; i < len; i++) exp_mem[i] = tb_words[i];
        exp_len = len;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (cpu_reset && n < 50) begin
            n++;
            cyc();
        end
        check("release cycles", 32'(n), 32'(RST_CYC));
        check("running", {31'b0, running}, 32'd1);
    endtask

    task automatic fetch_chk(input string nm, input logic [31:0] p,
                             input logic [31:0] ei, input logic eo);
        pc = p;
        #1;
        check({nm, " inst"}, inst, ei);
        cyc();
        check({nm, " pc_oob"}, {31'b0, pc_oob}, {31'b0, eo});
    endtask

    task automatic fetch_ref(input string nm, input logic [31:0] p);
        if (!ref_ok(p)) exp_oob = 1'b1;
        fetch_chk(nm, p, ref_inst(p), exp_oob);
    endtask

    initial begin
        logic [31:0] p;
        int          len;

        vecs[0] = '{32'h0000_0000, 32'h2001_0005, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h2002_0003, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'h0022_1820, 1'b0};
        vecs[3] = '{32'h0000_000C, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h2001_0005, 1'b1};
        vecs[6] = '{32'h0000_0200, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'h8000_0000, 32'h0000_0000, 1'b1};

        reset = 1'b0; load_start = 1'b0; load_len = '0; load_valid = 1'b0;
        load_data = '0; pc = 32'h0;
`ifdef LOAD_CKSUM_EN
        load_cksum = '0;
`endif
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        check("rst cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("rst load_ready", {31'b0, load_ready}, 32'd0);
        check("rst running", {31'b0, running}, 32'd0);
        check("rst pc_oob", {31'b0, pc_oob}, 32'd0);
        check("rst words_loaded", 32'(words_loaded), 32'd0);
        check("rst inst", inst, 32'h0);

        // Illegal lengths leave the block idle.
        for (int k = 0; k < 2; k++) begin
            load_start = 1'b1;
            load_len   = (k == 0) ? (AW+1)'(0) : (AW+1)'(NMEM + 1);
            cyc();
            load_start = 1'b0;
            cyc();
            check($sformatf("illegal%0d load_ready", k), {31'b0, load_ready}, 32'd0);
            check($sformatf("illegal%0d cpu_reset", k), {31'b0, cpu_reset}, 32'd1);
            check($sformatf("illegal%0d running", k), {31'b0, running}, 32'd0);
        end

        // Basic load, valid held high.
        tb_words[0] = 32'h2001_0005;
        tb_words[1] = 32'h2002_0003;
        tb_words[2] = 32'h0022_1820;
        send_load(3, 0, 1'b0);
        wait_run();
        for (int i = 0; i < 8; i++)
            fetch_chk($sformatf("vec%0d", i), vecs[i].pc, vecs[i].inst, vecs[i].oob);

        // Same image with valid gaps.
        tb_words[0] = 32'h1111_0001;
        tb_words[1] = 32'h2222_0002;
        tb_words[2] = 32'h3333_0003;
        pc = 32'h0;
        send_load(3, 1, 1'b0);
        wait_run();
        fetch_chk("gap w0", 32'h0, 32'h1111_0001, 1'b0);
        fetch_chk("gap w1", 32'h4, 32'h2222_0002, 1'b0);
        fetch_chk("gap w2", 32'h8, 32'h3333_0003, 1'b0);
        fetch_chk("gap w3", 32'hC, 32'h0, 1'b1);

        // Reload from RUN while pc_oob is set.
        tb_words[0] = 32'h0800_0000;
        send_load(1, 0, 1'b0);
        wait_run();
        fetch_chk("reload w0", 32'h0, 32'h0800_0000, 1'b0);
        fetch_chk("reload w1", 32'h4, 32'h0, 1'b1);

        // Asynchronous reset in the middle of a load.
        pc = 32'h0;
        load_start = 1'b1; load_len = (AW+1)'(5);
        cyc();
        load_start = 1'b0; load_valid = 1'b1; load_data = 32'hABCD_0000;
        repeat (2) cyc();
        check("midload words_loaded", 32'(words_loaded), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("async cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("async load_ready", {31'b0, load_ready}, 32'd0);
        check("async running", {31'b0, running}, 32'd0);
        check("async words_loaded", 32'(words_loaded), 32'd0);
        check("async pc_oob", {31'b0, pc_oob}, 32'd0);
        @(negedge clk);
        load_valid = 1'b0;
        reset = 1'b1;
        repeat (2) cyc();
        check("idle after reset inst", inst, 32'h0);
        check("idle after reset ready", {31'b0, load_ready}, 32'd0);

        // Randomized loads and fetches against the model.
        for (int it = 0; it < 6; it++) begin
            len = (it == 0) ? NMEM : int'($urandom_range(1, 24));
            for (int i = 0; i < len; i++) tb_words[i] = $urandom;
            send_load(len, 2, 1'b0);
            wait_run();
            for (int f = 0; f < 16; f++) begin
                case ($urandom_range(0, 3))
                    0:       p = 32'($urandom_range(0, len - 1)) << 2;
                    1:       p = 32'($urandom_range(0, NMEM - 1)) << 2;
                    2:       p = (32'($urandom_range(0, NMEM - 1)) << 2) | 32'($urandom_range(1, 3));
                    default: p = $urandom | 32'h0000_0200;
                endcase
                fetch_ref($sformatf("rnd%0d.%0d", it, f), p);
            end
            if (it == 0) fetch_ref("rnd top word", 32'h0000_01FC);
        end

`ifdef LOAD_CKSUM_EN
        tb_words[0] = 32'h2001_0005;
        tb_words[1] = 32'h2002_0003;
        send_load(2, 0, 1'b0);
        wait_run();
        check("ck good err", {31'b0, cksum_err}, 32'd0);
        send_load(2, 0, 1'b1);
        check("ck bad err", {31'b0, cksum_err}, 32'd1);
        check("ck bad cpu_reset", {31'b0, cpu_reset}, 32'd1);
        repeat (4) cyc();
        check("ck bad running", {31'b0, running}, 32'd0);
        check("ck bad held reset", {31'b0, cpu_reset}, 32'd1);
        check("ck bad words", 32'(words_loaded), 32'd2);
        send_load(2, 0, 1'b0);
        wait_run();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-side block directly upstream of the five-stage CPU.
- Accepts a program image streamed from the host transactor over a valid/ready handshake and stores it in on-chip word RAM.
- Holds the CPU in reset while loading, then releases it.
- Serves the CPU's `inst` combinationally from its `pc` output (0-cycle fetch), so the CPU's IF register captures it on the next posedge.

Parameters:
- AW, 7, word-address width; capacity NMEM = 2**AW words.
- RST_CYC, 2, cycles `cpu_reset` stays high in RELEASE before RUN (legal range 1..15).
- NOP_WORD, 32'h00000000, word returned for any invalid fetch.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- load_start  in  1  single-cycle request to begin loading; `load_len` sampled with it
- load_len  in  AW+1  number of words to load, legal 1..NMEM
- load_valid  in  1  host word valid
- load_data  in  32  host word
- load_ready  out  1  block accepts a word this cycle
- pc  in  32  CPU program counter
- inst  out  32  instruction word for `pc`
- cpu_reset  out  1  active-high reset to CPU, registered
- running  out  1  high in RUN
- pc_oob  out  1  sticky: invalid fetch seen in RUN
- words_loaded  out  AW+1  count of words written in the current/last load

Behaviour:
- Reset (`reset`=0, asynchronous):
  - state=IDLE, `cpu_reset`=1, `load_ready`=0, `running`=0, `pc_oob`=0, `words_loaded`=0, internal counters 0.
  - RAM contents are not cleared.
- States: IDLE, LOAD, RELEASE, RUN. All outputs except `inst` are registered.
- IDLE:
  - `load_start`=1 with 1<=`load_len`<=NMEM: latch length, clear `words_loaded`, go to LOAD; `load_ready`=1 from the next cycle.
  - `load_len`=0 or >NMEM: request ignored, stay IDLE.
- LOAD:
  - A transfer occurs on a posedge with `load_valid`&`load_ready`: `mem[words_loaded]`<=`load_data`, `words_loaded`++.
  - `load_ready` stays high through the cycle of the last transfer (`words_loaded`==len-1). It drops the next cycle, when the state becomes RELEASE.
  - `load_valid` gaps are allowed and cause no state change.
  - `load_start` is ignored in LOAD.
- RELEASE: `cpu_reset`=1 for exactly RST_CYC cycles (down-counter), then RUN.
- RUN:
  - `cpu_reset`=0, `running`=1.
  - `load_start` (legal length) → LOAD. `cpu_reset`=1 and `running`=0 from the next cycle, i.e. the CPU is reset before any RAM word changes.
- Fetch (combinational, RUN only):
  - Valid fetch requires all of: `pc[31:AW+2]`==0, `pc[1:0]`==0, and `pc[AW+1:2]` < `words_loaded`.
  - Valid: `inst`=`mem[pc[AW+1:2]]`.
  - Invalid: `inst`=NOP_WORD, and `pc_oob` sets on the next posedge.
  - In IDLE/LOAD/RELEASE, `inst`=NOP_WORD and `pc_oob` is never set.
- `pc_oob` clears only on `reset` or on an accepted `load_start`.
- Reset mid-LOAD or mid-RUN: immediate return to IDLE. Previously loaded words are unreachable until a new load.
- Width rules:
  - `words_loaded` is AW+1 bits so that NMEM is representable; the write index uses its low AW bits.
  - No wrap-around: LOAD ends at len ≤ NMEM.

Optional Feature:
- Macro: LOAD_CKSUM_EN.
- Defined:
  - Adds input `load_cksum` [31:0], sampled with `load_start`, and output `cksum_err` (reset 0).
  - A running XOR of accepted words (cleared on accepted `load_start`) is compared to the latched `load_cksum` when leaving LOAD.
  - Match: → RELEASE.
  - Mismatch: → IDLE with `cksum_err`=1, `cpu_reset` held 1, `words_loaded` retained; `cksum_err` clears on the next accepted `load_start`.
- Undefined: the extra ports and XOR logic are absent, and LOAD always proceeds to RELEASE.

Test Plan:
- Basic load: after reset, `load_start`, `load_len`=3, words 0x20010005, 0x20020003, 0x00221820 with `load_valid` held high.
  - `load_ready` high for exactly 3 accepting cycles; `words_loaded`=3.
  - `cpu_reset` stays 1 for 2 cycles in RELEASE, then falls; `running`=1.
  - `pc`=0x4 → `inst`=0x20020003.
- Handshake gaps: same load with `load_valid` toggled 1,0,0,1,0,1 → exactly 3 writes, words stored in order, no extra transfers.
- Out-of-range fetch: in RUN, drive `pc`=0xC (index 3 with 3 loaded) → `inst`=0x00000000 and `pc_oob`=1 next cycle. Then `pc`=0x2 → still NOP, `pc_oob` remains 1.
- Illegal length: in IDLE, `load_len`=0 and separately `load_len`=129 (AW=7) → state stays IDLE, `load_ready`=0, `cpu_reset`=1.
- Reload and async reset:
  - In RUN, `load_start` with `load_len`=1, word 0x08000000 → `cpu_reset`=1 the next cycle, `pc_oob` cleared, after RELEASE `inst`@`pc`=0 is 0x08000000.
  - `reset` low mid-load → all outputs at reset values within the same cycle.
- With LOAD_CKSUM_EN: `load_cksum`=0x20010005^0x20020003 while sending those 2 words → RUN. Wrong checksum 0x0 → IDLE, `cksum_err`=1, `cpu_reset`=1.
